// File: rtl/ram_responder_pkg.sv
// Shared encodings for the MOV/R_W/MOC memory handshake.
// The control unit imports this package too, so DT and R_W meanings stay in one place.
package ram_responder_pkg;

    // Data type field (DT)
    localparam logic [1:0] DT_BYTE       = 2'b00;
    localparam logic [1:0] DT_HALF       = 2'b01;
    localparam logic [1:0] DT_WORD       = 2'b10;
    localparam logic [1:0] DT_WORD_ALIAS = 2'b11;

    // R_W field
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Widest wait-state count the 4-bit counter can hold
    localparam int unsigned MAX_LATENCY = 15;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

    // Fold the word alias onto the canonical word code
    function automatic logic [1:0] dt_norm(input logic [1:0] dt);
        return (dt == DT_WORD_ALIAS) ? DT_WORD : dt;
    endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Combinational byte-lane steering for a big-endian, word-organised byte array.
// Lane k is the byte at (word base + k), so lane 0 is the most significant byte of a word.
module ram_lane_align
    import ram_responder_pkg::*;
(
    input  logic [1:0]       dt,
    input  logic [1:0]       offset,
    input  logic [31:0]      wdata,
    input  logic [3:0][7:0]  rbytes,
    output logic [3:0]       be,
    output logic [3:0][7:0]  wlanes,
    output logic [31:0]      rdata
);

    logic [1:0] dtn;

    assign dtn = dt_norm(dt);

    // Write side: byte enables and lane data; misaligned low bits are simply ignored
    always_comb begin
        be     = 4'b0000;
        wlanes = '0;
        unique case (dtn)
            DT_BYTE: begin
                be = 4'b0001 << offset;
                for (int k = 0; k < 4; k++) begin
                    wlanes[k] = wdata[7:0];
                end
            end
            DT_HALF: begin
                be        = offset[1] ? 4'b1100 : 4'b0011;
                wlanes[0] = wdata[15:8];
                wlanes[1] = wdata[7:0];
                wlanes[2] = wdata[15:8];
                wlanes[3] = wdata[7:0];
            end
            default: begin
                be        = 4'b1111;
                wlanes[0] = wdata[31:24];
                wlanes[1] = wdata[23:16];
                wlanes[2] = wdata[15:8];
                wlanes[3] = wdata[7:0];
            end
        endcase
    end

    // Read side: pick the addressed lanes, right-justify and zero-extend
    always_comb begin
        rdata = '0;
        unique case (dtn)
            DT_BYTE: rdata = {24'h0, rbytes[offset]};
            DT_HALF: rdata = offset[1] ? {16'h0, rbytes[2], rbytes[3]}
                                       : {16'h0, rbytes[0], rbytes[1]};
            default: rdata = {rbytes[0], rbytes[1], rbytes[2], rbytes[3]};
        endcase
    end

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the MOV/R_W/MOC four-phase handshake.
// Holds the byte array, the request registers, the wait-state counter and the FSM.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     MOV,
    input  logic                     R_W,
    input  logic [1:0]               DT,
    input  logic [31:0]              Address,
    input  logic [31:0]              DataIn,
    output logic [31:0]              DataOut,
    output logic                     MOC,
    input  logic                     ld,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [7:0]               ld_byte
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]      mem [DEPTH];

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            moc_q, moc_d;
    logic [31:0]     dout_q, dout_d;

    logic [AW-1:0]   addr_q;
    logic            rw_q;
    logic [1:0]      dt_q;
    logic [31:0]     wdata_q;

    logic            latch;
    logic            do_write;
    logic            ld_en;

    logic [3:0]      be;
    logic [3:0][7:0] wlanes;
    logic [3:0][7:0] rbytes;
    logic [31:0]     rdata;

    // Address bits above the array size are deliberately dropped (modulo DEPTH)
    logic            unused_addr_hi;
    assign unused_addr_hi = ^Address[31:AW];

    ram_lane_align u_align (
        .dt     (dt_q),
        .offset (addr_q[1:0]),
        .wdata  (wdata_q),
        .rbytes (rbytes),
        .be     (be),
        .wlanes (wlanes),
        .rdata  (rdata)
    );

    // Fetch the four bytes of the word containing the latched address
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rbytes[k] = mem[{addr_q[AW-1:2], 2'(k)}];
        end
    end

    // Preload only when idle and no request is competing for the array
    assign ld_en = ld && (state_q == IDLE) && !MOV && !clr;

    // Next-state, counter, MOC and read-data update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        moc_d    = moc_q;
        dout_d   = dout_q;
        latch    = 1'b0;
        do_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (MOV) begin
                    latch   = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!MOV) begin
                    // Abort: nothing is committed and DataOut keeps its value
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    moc_d   = 1'b1;
                    if (rw_q == RW_READ) begin
                        dout_d = rdata;
                    end else begin
                        do_write = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (!MOV) begin
                    state_d = IDLE;
                    moc_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                moc_d   = 1'b0;
            end
        endcase
    end

    // FSM, counter and output registers; clr aborts any access in flight
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            moc_q   <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            moc_q   <= moc_d;
            dout_q  <= dout_d;
        end
    end

    // Request capture at acceptance; later changes on the bus are ignored
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            addr_q  <= '0;
            rw_q    <= RW_READ;
            dt_q    <= DT_BYTE;
            wdata_q <= 32'h0;
        end else if (latch) begin
            addr_q  <= Address[AW-1:0];
            rw_q    <= R_W;
            dt_q    <= DT;
            wdata_q <= DataIn;
        end
    end

    // Byte array: write commit at DONE entry, or a preload byte; never cleared by clr
    always_ff @(posedge clk) begin
        if (do_write && !clr) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[{addr_q[AW-1:2], 2'(k)}] <= wlanes[k];
                end
            end
        end else if (ld_en) begin
            mem[ld_addr] <= ld_byte;
        end
    end

    assign MOC     = moc_q;
    assign DataOut = dout_q;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: byte-array model plus a read-data scoreboard queue.
module tb_ram_responder;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LATENCY = 2;
    localparam int          BOUND   = 40;

    logic        clk = 1'b0;
    logic        clr;
    logic        MOV;
    logic        R_W;
    logic [1:0]  DT;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        ld;
    logic [7:0]  ld_addr;
    logic [7:0]  ld_byte;

    logic [7:0]  model [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] last_dout;
    int          n_checks = 0;
    int          n_errors = 0;

    ram_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .MOV     (MOV),
        .R_W     (R_W),
        .DT      (DT),
        .Address (Address),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .MOC     (MOC),
        .ld      (ld),
        .ld_addr (ld_addr),
        .ld_byte (ld_byte)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Big-endian reference read with forced alignment and modulo-DEPTH wrap
    function automatic logic [31:0] model_read(input logic [1:0] dt, input logic [31:0] addr);
        logic [7:0] a;
        a = addr[7:0];
        if (dt == 2'b00) begin
            return {24'h0, model[a]};
        end else if (dt == 2'b01) begin
            a[0] = 1'b0;
            return {16'h0, model[a], model[a + 8'd1]};
        end else begin
            a[1:0] = 2'b00;
            return {model[a], model[a + 8'd1], model[a + 8'd2], model[a + 8'd3]};
        end
    endfunction

    function automatic void model_write(input logic [1:0] dt, input logic [31:0] addr,
                                        input logic [31:0] d);
        logic [7:0] a;
        a = addr[7:0];
        if (dt == 2'b00) begin
            model[a] = d[7:0];
        end else if (dt == 2'b01) begin
            a[0] = 1'b0;
            model[a]        = d[15:8];
            model[a + 8'd1] = d[7:0];
        end else begin
            a[1:0] = 2'b00;
            model[a]        = d[31:24];
            model[a + 8'd1] = d[23:16];
            model[a + 8'd2] = d[15:8];
            model[a + 8'd3] = d[7:0];
        end
    endfunction

    // One full handshake; hold = extra cycles MOV stays high after MOC; with_ld keeps ld high
    task automatic access(input logic rw, input logic [1:0] dt, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold, input logic with_ld);
        int cyc;
        MOV     = 1'b1;
        R_W     = rw;
        DT      = dt;
        Address = addr;
        DataIn  = wdata;
        ld      = with_ld;
        ld_addr = addr[7:0];
        ld_byte = ~model[addr[7:0]];
        if (rw) exp_q.push_back(model_read(dt, addr));
        else    model_write(dt, addr, wdata);
        @(posedge clk); #1;
        // Bus changes after acceptance must not matter
        Address = $urandom;
        DataIn  = $urandom;
        R_W     = ~rw;
        DT      = ~dt;
        cyc = 0;
        while (!MOC && cyc < BOUND) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, LATENCY);
        if (MOC) begin
            if (rw) begin
                last_dout = exp_q.pop_front();
                check("rdata", DataOut, last_dout);
            end else begin
                check("wr_dout", DataOut, last_dout);
            end
        end
        ld = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("moc_hold", {31'h0, MOC}, 32'h1);
        end
        MOV = 1'b0;
        @(posedge clk); #1;
        check("moc_fall", {31'h0, MOC}, 32'h0);
    endtask

    initial begin
        int cyc;
        clr = 1'b1; MOV = 1'b0; R_W = 1'b1; DT = 2'b00;
        Address = '0; DataIn = '0; ld = 1'b0; ld_addr = '0; ld_byte = '0;
        last_dout = 32'h0;

        #12;
        check("rst_moc", {31'h0, MOC}, 32'h0);
        check("rst_dout", DataOut, 32'h0);
        clr = 1'b0;
        @(posedge clk); #1;

        // Preload every byte so the model is fully defined
        for (int i = 0; i < int'(DEPTH); i++) begin
            ld      = 1'b1;
            ld_addr = 8'(i);
            case (i)
                0:       ld_byte = 8'hE3;
                1:       ld_byte = 8'hA0;
                2:       ld_byte = 8'h10;
                3:       ld_byte = 8'h05;
                default: ld_byte = 8'($urandom);
            endcase
            model[i] = ld_byte;
            @(posedge clk); #1;
        end
        ld = 1'b0;

        access(1'b1, 2'b10, 32'h0, 32'h0, 0, 1'b0);
        check("word0_const", DataOut, 32'hE3A01005);

        access(1'b0, 2'b00, 32'h5, 32'h0000_00AB, 0, 1'b0);
        access(1'b1, 2'b10, 32'h4, 32'h0, 0, 1'b0);
        access(1'b1, 2'b10, 32'h0, 32'h0, 0, 1'b0);

        access(1'b1, 2'b01, 32'h3, 32'h0, 0, 1'b0);
        access(1'b1, 2'b10, DEPTH + 8, 32'h0, 0, 1'b0);
        access(1'b1, 2'b11, 32'h9, 32'h0, 0, 1'b0);

        // Abort during WAIT: the write must never land
        MOV = 1'b1; R_W = 1'b0; DT = 2'b10; Address = 32'h10; DataIn = 32'hDEADBEEF;
        @(posedge clk); #1;
        MOV = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_moc", {31'h0, MOC}, 32'h0);
        end
        check("abort_dout", DataOut, last_dout);
        access(1'b1, 2'b10, 32'h10, 32'h0, 0, 1'b0);

        // Preload strobe concurrent with a request is ignored
        access(1'b1, 2'b00, 32'h20, 32'h0, 0, 1'b1);
        access(1'b1, 2'b00, 32'h20, 32'h0, 0, 1'b0);

        // clr while in DONE
        MOV = 1'b1; R_W = 1'b1; DT = 2'b10; Address = 32'h40;
        exp_q.push_back(model_read(2'b10, 32'h40));
        @(posedge clk); #1;
        cyc = 0;
        while (!MOC && cyc < BOUND) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("clr_latency", cyc, LATENCY);
        if (MOC) begin
            last_dout = exp_q.pop_front();
            check("clr_rdata", DataOut, last_dout);
        end
        #2 clr = 1'b1;
        #1;
        check("clr_moc", {31'h0, MOC}, 32'h0);
        check("clr_dout", DataOut, 32'h0);
        last_dout = 32'h0;
        MOV = 1'b0;
        #1 clr = 1'b0;
        @(posedge clk); #1;
        access(1'b1, 2'b10, 32'h40, 32'h0, 0, 1'b0);

        // Long MOV hold past MOC, then an immediate back-to-back request
        access(1'b1, 2'b10, 32'hC, 32'h0, 4, 1'b0);
        access(1'b0, 2'b01, 32'h31, 32'h0000_1234, 0, 1'b0);
        access(1'b1, 2'b10, 32'h30, 32'h0, 0, 1'b0);

        // Mixed random traffic including wrap of high address bits
        for (int i = 0; i < 16; i++) begin
            access(1'($urandom), 2'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)),
                   1'b0);
        end
        access(1'b1, 2'b10, DEPTH - 4, 32'h0, 0, 1'b0);

        check("sb_empty", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
# ram_responder

Memory-side responder for the control unit's MOV/R_W/MOC memory handshake. Accepts byte, halfword and word reads and writes from the CPU datapath. Inserts a programmable number of wait states and signals completion with MOC. Sits between MAR/MDR and the rest of the CPU, replacing the ad-hoc memory model in the CPU bench.

## Interface
- DEPTH, 256: memory size in bytes; power of two, 16..65536.
- LATENCY, 2: wait cycles from accepted request to MOC; legal range 1..15.
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  asynchronous, active-high reset.
- MOV  in  1  memory operation valid, from control unit; held until MOC seen.
- R_W  in  1  1 = read, 0 = write; sampled with request.
- DT  in  2  data type: 00 byte, 01 halfword, 10 word, 11 word (alias).
- Address  in  32  byte address from MAR; only low log2(DEPTH) bits used.
- DataIn  in  32  write data from MDR, right-justified.
- DataOut  out  32  read data to MDR, right-justified, zero-extended.
- MOC  out  1  memory operation complete.
- ld  in  1  bench/boot preload strobe, one byte per cycle.
- ld_addr  in  log2(DEPTH)  preload byte address.
- ld_byte  in  8  preload byte.

## Operation
- **Reset values (async on clr=1):** state IDLE, MOC=0, DataOut=0, counter=0. The memory array is NOT cleared.
- **FSM states:** IDLE, WAIT, DONE.
- **IDLE**
  - MOV=1 at a rising edge latches Address, R_W, DT and DataIn into request registers.
  - Loads counter with LATENCY-1 and goes to WAIT.
- **WAIT**
  - MOV=0: abort. Go to IDLE; no write, DataOut unchanged.
  - Else if counter==0: perform the access and go to DONE with MOC=1.
  - Else decrement the counter.
- **DONE**
  - MOC held at 1 while MOV=1.
  - MOV=0 → IDLE, MOC=0 at the same edge.
  - The CU must not start a new request without dropping MOV (four-phase handshake).
- **Byte order:** big-endian. Word at address a = {m[a], m[a+1], m[a+2], m[a+3]}. Halfword = {m[a], m[a+1]}.
- **Alignment:** halfword forces Address[0]=0; word forces Address[1:0]=00. No fault is raised.
- **Wrap:** the address is taken modulo DEPTH; a word at DEPTH-4 is the last legal word.
- **Reads:** DataOut updated at the DONE entry edge with zero-extended data; held until the next completed read. Writes never change DataOut.
- **Writes:** only the DT-selected bytes change, from the low bits of latched DataIn. Committed at the DONE entry edge.
- **Preload:** ld=1 in IDLE with MOV=0 writes ld_byte to m[ld_addr]. Ignored in WAIT/DONE, and in IDLE when MOV=1 (the request wins).
- **Reset mid-operation:** aborts the access; a pending write is never committed.

## Timing
- Request sampled at edge n → MOC rises after edge n+LATENCY. DataOut is valid in the same cycle as MOC.
- MOC falls at the first edge where MOV=0 is sampled in DONE. The earliest next request is accepted one edge later (from IDLE).
- Request inputs are registered at acceptance; changes to Address/DataIn during WAIT/DONE have no effect.
- Preload: one byte per edge, visible to a read accepted at the next edge.

## Structure
- **Shared package:** DT encodings (DT_BYTE, DT_HALF, DT_WORD), state enum (IDLE/WAIT/DONE), R_W encoding constants. The control unit must use the same package.
- **Sub-module `ram_lane_align`:** combinational.
  - Write side: from DT and the low address bits, produces 4 byte-write enables and the big-endian lane data.
  - Read side: from the 4 read bytes, produces the right-justified, zero-extended DataOut value.
- The FSM, counter and byte array live in ram_responder.

## Test plan
- Preload m[0..3]=E3,A0,10,05; word read at Address 0, LATENCY=2 → MOC rises 2 edges after acceptance, DataOut=E3A01005.
- Byte write DataIn=0000_00AB at Address 5, then word read at 4 → DataOut={m4,AB,m6,m7}; other bytes unchanged.
- Halfword read at Address 3 → treated as address 2, DataOut=0000_{m2,m3}. Word read at DEPTH+8 → same as address 8.
- MOV dropped during WAIT before a word write of DEADBEEF to 0x10 → MOC never rises; a later read of 0x10 returns the old contents.
- clr pulsed in DONE → MOC=0 and DataOut=0 immediately; memory contents preserved.
- MOV held 4 cycles past MOC → MOC stays 1; MOV low → MOC 0 next edge. A new request accepted the edge after completes normally.
